booth_seq_ctrl: RTL and testbench

//  Sequencer for the radix-2 Booth shift-add datapath: accepts one signed WIDTH x WIDTH

---
 rtl/booth_seq_ctrl_pkg.sv | 26 ++
 rtl/booth_seq_ctrl_if.sv | 24 ++
 rtl/booth_seq_ctrl_booth_step.sv | 32 +++
 rtl/booth_seq_ctrl.sv | 94 +++++++++
 tb/tb_booth_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_seq_ctrl_pkg.sv
// Shared encodings for the Booth multiplier family.
// State codes and Booth op decode used by the sequencer and step.
package booth_seq_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  function automatic logic [1:0] booth_op(
    input logic [1:0] i_pair
  );
    logic [1:0] w_op;
    w_op = OP_NOP;
    case (i_pair)
      2'b01:   w_op = OP_ADD;
      2'b10:   w_op = OP_SUB;
      default: w_op = OP_NOP;
    endcase
    return w_op;
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand issue / product return handshake bundle.
// Master is the issuer+consumer side, slave is the sequencer.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_seq_ctrl_booth_step.sv
// One radix-2 Booth iteration on R = {ACC, Q, Qm1}:
// conditional add/sub into ACC, then arithmetic right shift of R.
module booth_step
  import booth_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] i_r,
  input  logic [WIDTH:0]     i_m,
  input  logic [WIDTH:0]     i_mn,
  output logic [2*WIDTH+1:0] o_r
);

  logic [1:0]         w_op;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_acc;
  logic [2*WIDTH+1:0] w_sum;

  always_comb begin
    w_op     = booth_op(i_r[1:0]);
    w_addend = '0;
    unique case (1'b1)
      (w_op == OP_ADD): w_addend = i_m;
      (w_op == OP_SUB): w_addend = i_mn;
      default:          w_addend = '0;
    endcase
    w_acc = i_r[2*WIDTH+1:WIDTH+1] + w_addend;
    w_sum = {w_acc, i_r[WIDTH:0]};
    o_r   = {w_sum[2*WIDTH+1], w_sum[2*WIDTH+1:1]};
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer for the radix-2 Booth shift-add multiplier.
// Loads R, steps it WIDTH times, then holds the product.
module booth_seq_ctrl
  import booth_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic              clk,
  input logic              rst_n,
  booth_seq_ctrl_if.slave  bus
);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH+1:0] r_work;
  logic [WIDTH:0]     r_m;
  logic [WIDTH:0]     r_mn;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [2*WIDTH+1:0] w_next;
  logic [WIDTH:0]     w_m;
  logic               w_accept;
  logic               w_handoff;
  logic               w_last;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r  (r_work),
    .i_m  (r_m),
    .i_mn (r_mn),
    .o_r  (w_next)
  );

  // ACC is one bit wider so negating the most negative operand is exact
  assign w_m       = {bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign w_accept  = r_in_ready && bus.in_valid;
  assign w_handoff = r_out_valid && bus.out_ready;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_m         <= '0;
      r_mn        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (w_accept) begin
            r_work     <= {{(WIDTH+1){1'b0}}, bus.multiplier, 1'b0};
            r_m        <= w_m;
            r_mn       <= -w_m;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        (r_state == ST_RUN): begin
          r_work <= w_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        (r_state == ST_DONE): begin
          if (w_handoff) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_work[2*WIDTH:1];
  assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: directed vectors plus a queue model
// of in-flight multiplies checked every cycle on the falling edge.
module tb_booth_seq_ctrl;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;
  logic chk_en;
  logic prev_ov;

  booth_seq_ctrl_if #(.WIDTH(W)) bus ();

  booth_seq_ctrl #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] p;
    int          acc;
  } exp_t;

  exp_t q[$];

  function automatic logic [63:0] ref_mul(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Model: a multiply is in flight from its accept until its handoff
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
      chk("busy", 64'(bus.busy), 64'(q.size() != 0));
      if (bus.out_valid) begin
        chk("valid_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          chk("product_model", bus.product, q[0].p);
          if (!prev_ov)
            chk("latency", 64'(cyc - q[0].acc), 64'(W + 1));
        end
      end else if (q.size() != 0) begin
        chk("valid_not_late", 64'(cyc - q[0].acc <= W + 1), 64'd1);
      end
    end
    prev_ov = bus.out_valid;
    if (!rst_n) q.delete();
    else begin
      if (bus.out_valid && bus.out_ready && q.size() != 0)
        void'(q.pop_front());
      if (bus.in_valid && bus.in_ready)
        q.push_back('{p: ref_mul(bus.multiplicand, bus.multiplier),
                      acc: cyc});
    end
  end

  task automatic wait_accept(output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        acc_cyc = cyc;
        break;
      end
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
    end
    chk("valid_timeout", 64'(ok), 64'd1);
  endtask

  task automatic run_mul(
    input string       nm,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] exp
  );
    int ac;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.in_valid     = 1'b1;
    wait_accept(ac);
    bus.in_valid     = 1'b0;
    bus.multiplicand = '1;
    bus.multiplier   = '1;
    wait_valid();
    chk(nm, bus.product, exp);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] va[4];
  logic [31:0] vb[4];
  int          acc6[4];
  int          ac;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    chk_en = 1'b0;
    prev_ov = 1'b0;
    rst_n  = 1'b0;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    run_mul("mul_3x5", 32'd3, 32'd5, 64'd15);
    @(negedge clk);
    chk("valid_one_cycle", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    run_mul("mul_m7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    run_mul("mul_0xm1", 32'd0, 32'hFFFF_FFFF, 64'd0);
    run_mul("mul_minxmin", 32'h8000_0000, 32'h8000_0000,
            64'h4000_0000_0000_0000);
    run_mul("mul_minx1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

    // Backpressure: product held, extra operands ignored
    bus.out_ready    = 1'b0;
    bus.multiplicand = 32'd1234;
    bus.multiplier   = 32'hFFFF_E9D2;
    bus.in_valid     = 1'b1;
    wait_accept(ac);
    bus.in_valid = 1'b0;
    wait_valid();
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid     = (i >= 3 && i < 6);
      bus.multiplicand = 32'd77;
      bus.multiplier   = 32'd99;
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_product", bus.product, 64'hFFFF_FFFF_FF95_1644);
      chk("bp_no_accept", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("release_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a run
    bus.multiplicand = 32'd12345;
    bus.multiplier   = 32'd678;
    bus.in_valid     = 1'b1;
    wait_accept(ac);
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_product", bus.product, 64'd0);
    @(posedge clk);
    #1;
    run_mul("mul_2x3", 32'd2, 32'd3, 64'd6);

    // Back-to-back with in_valid held high
    va[0] = 32'd1234;       vb[0] = 32'hFFFF_E9D2;
    va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;
    va[2] = 32'h7FFF_FFFF;  vb[2] = 32'h7FFF_FFFF;
    va[3] = 32'hFFFE_7960;  vb[3] = 32'd30000;
    for (int i = 0; i < 4; i++) begin
      bus.multiplicand = va[i];
      bus.multiplier   = vb[i];
      bus.in_valid     = 1'b1;
      wait_accept(acc6[i]);
    end
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", 64'(acc6[i] - acc6[i-1]), 64'(W + 2));
    wait_valid();
    chk("b2b_last_lit", bus.product, 64'hFFFF_FFFF_4D2F_A200);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
